// File: rtl/simmem_pkg.sv
// Shared types and constants for the simulated-memory model.
package simmem_pkg;

  localparam int unsigned IDWidth              = 4;
  localparam int unsigned WRespSchedNumSlots   = 8;
  localparam int unsigned WRespSchedDelayWidth = 6;

  typedef struct packed {
    logic [IDWidth-1:0]              id;
    logic [WRespSchedDelayWidth-1:0] countdown;
  } wresp_sched_slot_t;

  typedef enum logic {
    ArbIdle,
    ArbLocked
  } wresp_arb_state_e;

endpackage

// File: rtl/simmem_rr_arbiter.sv
// Rotating-priority arbiter: grants the first request at or after ptr (cyclic).
module simmem_rr_arbiter #(
  parameter int unsigned N        = 8,
  parameter int unsigned IdxWidth = $clog2(N)
) (
  input  logic [N-1:0]        req,
  input  logic [IdxWidth-1:0] ptr,
  output logic [N-1:0]        gnt,
  output logic [IdxWidth-1:0] idx,
  output logic                valid
);

  logic [IdxWidth-1:0] cand;

  // NOTE: every output gets a default before the loop, so no path leaves a latch.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 0; k < int'(N); k++) begin
      // N is a power of two, so index wrap is plain truncation.
      cand = ptr + IdxWidth'(k);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/simmem_wresp_scheduler.sv
// Write-response scheduler: per-slot latency countdown, per-ID ordering, RR release.
// Optional statistics counters are enabled with `define SIMMEM_WRESP_SCHED_STATS_EN.
module simmem_wresp_scheduler
  import simmem_pkg::*;
#(
  parameter int unsigned NumSlots     = WRespSchedNumSlots,
  parameter int unsigned DelayWidth   = WRespSchedDelayWidth,
  parameter int unsigned SlotIdxWidth = $clog2(NumSlots)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [IDWidth-1:0]      aw_id_i,
  input  logic [DelayWidth-1:0]   delay_i,
  output logic                    release_valid_o,
  input  logic                    release_ready_i,
  output logic [IDWidth-1:0]      release_id_o,
  output logic [SlotIdxWidth-1:0] release_slot_o,
  output logic [SlotIdxWidth:0]   occupancy_o
`ifdef SIMMEM_WRESP_SCHED_STATS_EN
  ,
  output logic [31:0]             stat_released_o,
  output logic [SlotIdxWidth:0]   stat_max_occ_o,
  output logic [31:0]             stat_stall_cycles_o
`endif
);

  wresp_sched_slot_t     slot_q  [NumSlots];
  logic [NumSlots-1:0]   older_q [NumSlots];
  logic [NumSlots-1:0]   valid_q;
  logic [SlotIdxWidth-1:0] rr_ptr_q, locked_slot_q, alloc_idx, arb_idx, rel_slot;
  logic [SlotIdxWidth:0] occ_q, occ_d;
  logic [NumSlots-1:0]   eligible, arb_gnt, rel_mask;
  logic                  arb_valid, rel_valid, aw_hs, rel_hs;
  wresp_arb_state_e      state_q, state_d;

  assign aw_ready_o = ~&valid_q;
  assign aw_hs      = aw_valid_i & aw_ready_o;
  assign rel_hs     = rel_valid & release_ready_i;

  always_comb begin
    alloc_idx = '0;
    for (int i = int'(NumSlots) - 1; i >= 0; i--)
      if (!valid_q[i]) alloc_idx = SlotIdxWidth'(i);
  end

  // A slot is blocked while any older pending slot carries the same ID.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < int'(NumSlots); i++) begin
      eligible[i] = valid_q[i] && (slot_q[i].countdown == '0);
      for (int j = 0; j < int'(NumSlots); j++)
        if (valid_q[j] && older_q[i][j] && (slot_q[j].id == slot_q[i].id))
          eligible[i] = 1'b0;
    end
  end

  simmem_rr_arbiter #(.N(NumSlots), .IdxWidth(SlotIdxWidth)) u_arb (
    .req   (eligible),
    .ptr   (rr_ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    state_d   = state_q;
    rel_valid = 1'b0;
    rel_slot  = '0;
    unique case (state_q)
      ArbIdle: if (arb_valid) begin
        rel_valid = 1'b1;
        rel_slot  = arb_idx;
        if (!release_ready_i) state_d = ArbLocked;
      end
      ArbLocked: begin
        rel_valid = 1'b1;
        rel_slot  = locked_slot_q;
        if (release_ready_i) state_d = ArbIdle;
      end
      default: state_d = ArbIdle;
    endcase
  end

  assign release_valid_o = rel_valid;
  assign release_slot_o  = rel_slot;
  assign release_id_o    = rel_valid ? slot_q[rel_slot].id : '0;

  always_comb begin
    rel_mask = '0;
    if (rel_hs) rel_mask[rel_slot] = 1'b1;
    occ_d = occ_q;
    if (aw_hs && !rel_hs)      occ_d = occ_q + (SlotIdxWidth+1)'(1);
    else if (!aw_hs && rel_hs) occ_d = occ_q - (SlotIdxWidth+1)'(1);
  end

  assign occupancy_o = occ_q;

  // NOTE: sequential state uses non-blocking assignments only, so later writes in
  // this block (allocation row) cleanly override earlier ones (column clears).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ArbIdle;
      valid_q       <= '0;
      rr_ptr_q      <= '0;
      locked_slot_q <= '0;
      occ_q         <= '0;
      // NOTE: the slot array is reset too, so a discarded slot can never leak state.
      for (int i = 0; i < int'(NumSlots); i++) begin
        slot_q[i]  <= '0;
        older_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      if (state_q == ArbIdle) locked_slot_q <= arb_idx;
      for (int i = 0; i < int'(NumSlots); i++)
        if (valid_q[i] && slot_q[i].countdown != '0)
          slot_q[i].countdown <= slot_q[i].countdown - DelayWidth'(1);
      if (rel_hs) begin
        valid_q[rel_slot] <= 1'b0;
        rr_ptr_q          <= rel_slot + SlotIdxWidth'(1);
        for (int i = 0; i < int'(NumSlots); i++) older_q[i][rel_slot] <= 1'b0;
      end
      if (aw_hs) begin
        for (int i = 0; i < int'(NumSlots); i++) older_q[i][alloc_idx] <= 1'b0;
        valid_q[alloc_idx] <= 1'b1;
        slot_q[alloc_idx]  <= '{id: aw_id_i, countdown: delay_i};
        older_q[alloc_idx] <= valid_q & ~rel_mask;
      end
    end
  end

`ifdef SIMMEM_WRESP_SCHED_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_released_o     <= '0;
      stat_max_occ_o      <= '0;
      stat_stall_cycles_o <= '0;
    end else begin
      if (rel_hs)                   stat_released_o     <= stat_released_o + 32'd1;
      if (aw_valid_i && !aw_ready_o) stat_stall_cycles_o <= stat_stall_cycles_o + 32'd1;
      if (occ_d > stat_max_occ_o)   stat_max_occ_o      <= occ_d;
    end
  end
`endif

endmodule

// File: tb/tb_simmem_wresp_scheduler.sv
// Directed bench for simmem_wresp_scheduler; inputs driven and outputs sampled at negedge.
module tb_simmem_wresp_scheduler;
  import simmem_pkg::*;

  localparam int SIW = $clog2(WRespSchedNumSlots);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               aw_valid = 1'b0;
  logic               aw_ready;
  logic [IDWidth-1:0] aw_id = '0;
  logic [5:0]         delay = '0;
  logic               rel_valid;
  logic               rel_ready = 1'b0;
  logic [IDWidth-1:0] rel_id;
  logic [SIW-1:0]     rel_slot;
  logic [SIW:0]       occ;
`ifdef SIMMEM_WRESP_SCHED_STATS_EN
  logic [31:0]        stat_released, stat_stall;
  logic [SIW:0]       stat_max_occ;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  simmem_wresp_scheduler dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .aw_valid_i      (aw_valid),
    .aw_ready_o      (aw_ready),
    .aw_id_i         (aw_id),
    .delay_i         (delay),
    .release_valid_o (rel_valid),
    .release_ready_i (rel_ready),
    .release_id_o    (rel_id),
    .release_slot_o  (rel_slot),
    .occupancy_o     (occ)
`ifdef SIMMEM_WRESP_SCHED_STATS_EN
    ,
    .stat_released_o     (stat_released),
    .stat_max_occ_o      (stat_max_occ),
    .stat_stall_cycles_o (stat_stall)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1; aw_valid = 1'b0; rel_ready = 1'b0;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_rv(input int limit, output int waited);
    waited = 0;
    while (!rel_valid && waited < limit) begin
      step(); #1;
      waited++;
    end
    if (!rel_valid) check("wait_rv_timeout", rel_valid, 1);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (occ != 0 && n < limit) begin
      step(); #1;
      n++;
    end
    check("drain_occ", occ, 0);
  endtask

  initial begin
    int waited;
    int highs;

    // Reset state
    do_reset();
    check("rst_aw_ready", aw_ready, 1);
    check("rst_rel_valid", rel_valid, 0);
    check("rst_rel_id", rel_id, 0);
    check("rst_rel_slot", rel_slot, 0);
    check("rst_occ", occ, 0);

    // Single AW id=3 delay=5: release in the 6th cycle after acceptance
    step();
    aw_valid = 1'b1; aw_id = 4'd3; delay = 6'd5; rel_ready = 1'b1;
    #1;
    check("t1_aw_ready", aw_ready, 1);
    step();
    aw_valid = 1'b0;
    #1;
    for (int k = 1; k <= 5; k++) begin
      check("t1_no_early_release", rel_valid, 0);
      check("t1_occ_pending", occ, 1);
      step(); #1;
    end
    check("t1_rel_valid", rel_valid, 1);
    check("t1_rel_id", rel_id, 3);
    check("t1_rel_slot", rel_slot, 0);
    step(); #1;
    check("t1_occ_after", occ, 0);
    check("t1_rel_valid_after", rel_valid, 0);

    // Same-ID ordering: younger delay-0 slot waits behind older delay-10 slot
    aw_valid = 1'b1; aw_id = 4'd2; delay = 6'd10;
    #1;
    step();
    aw_id = 4'd2; delay = 6'd0;
    #1;
    check("t2_idle", rel_valid, 0);
    step();
    aw_valid = 1'b0;
    #1;
    check("t2_order_block", rel_valid, 0);
    wait_rv(40, waited);
    check("t2_first_wait", waited, 9);
    check("t2_first_slot", rel_slot, 0);
    check("t2_first_id", rel_id, 2);
    step(); #1;
    check("t2_second_valid", rel_valid, 1);
    check("t2_second_slot", rel_slot, 1);
    check("t2_second_id", rel_id, 2);
    step(); #1;
    check("t2_done_valid", rel_valid, 0);
    check("t2_done_occ", occ, 0);

    // Fill all 8 slots with delay 63; 9th AW stalls until a slot is freed
    do_reset();
    rel_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      aw_valid = 1'b1; aw_id = IDWidth'(i); delay = 6'd63;
      #1;
      check("t3_fill_ready", aw_ready, 1);
      step();
    end
    aw_id = 4'd9; delay = 6'd0;
    #1;
    check("t3_full_ready", aw_ready, 0);
    check("t3_full_occ", occ, 8);
    wait_rv(100, waited);
    check("t3_first_wait", waited, 56);
    check("t3_first_slot", rel_slot, 0);
    check("t3_still_stalled", aw_ready, 0);
    step(); #1;
    check("t3_accept_ready", aw_ready, 1);
    check("t3_occ_after_free", occ, 7);
    check("t3_second_slot", rel_slot, 1);
    step();
    aw_valid = 1'b0;
    #1;
    check("t3_occ_simul", occ, 7);
    drain(50);

    // Backpressure: granted slot 1 is held; slot 0 becoming eligible must not preempt
    do_reset();
    aw_valid = 1'b1; aw_id = 4'd5; delay = 6'd3;
    step();
    aw_id = 4'd6; delay = 6'd0;
    #1;
    check("t4_idle", rel_valid, 0);
    step();
    aw_valid = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("t4_hold_valid", rel_valid, 1);
      check("t4_hold_slot", rel_slot, 1);
      check("t4_hold_id", rel_id, 6);
      step(); #1;
    end
    rel_ready = 1'b1;
    #1;
    check("t4_hs_slot", rel_slot, 1);
    step(); #1;
    check("t4_next_valid", rel_valid, 1);
    check("t4_next_slot", rel_slot, 0);
    check("t4_next_id", rel_id, 5);
    step(); #1;
    check("t4_done_valid", rel_valid, 0);
    check("t4_done_occ", occ, 0);

    // Round-robin: ids 1..4 in slots 0..3 released in order
    do_reset();
    for (int i = 0; i < 4; i++) begin
      aw_valid = 1'b1; aw_id = IDWidth'(i + 1); delay = 6'd0;
      step();
    end
    aw_valid = 1'b0;
    rel_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t5_rr_slot", rel_slot, i);
      check("t5_rr_valid", rel_valid, 1);
      step(); #1;
    end
    check("t5_rr_occ", occ, 0);
    // rr_ptr is 4: all 8 slots eligible together -> 4,5,6,7,0,1,2,3
    for (int i = 0; i < 8; i++) begin
      aw_valid = 1'b1; aw_id = IDWidth'(i); delay = 6'(7 - i);
      step();
    end
    aw_valid = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      check("t5_wrap_slot", rel_slot, (i + 4) % 8);
      check("t5_wrap_id", rel_id, (i + 4) % 8);
      step(); #1;
    end
    check("t5_wrap_occ", occ, 0);

    // Mid-operation reset with 5 pending slots
    for (int i = 0; i < 5; i++) begin
      aw_valid = 1'b1; aw_id = IDWidth'(i); delay = 6'd20;
      step();
    end
    aw_valid = 1'b0;
    #1;
    check("t6_occ_pending", occ, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("t6_rst_occ", occ, 0);
    check("t6_rst_valid", rel_valid, 0);
    check("t6_rst_ready", aw_ready, 1);
    highs = 0;
    for (int k = 0; k < 30; k++) begin
      if (rel_valid) highs++;
      step(); #1;
    end
    check("t6_no_stale_release", highs, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
